// File: rtl/led_sequencer_pkg.sv
// led_seq_pkg: shared types and constants for the LED colour sequencer.
//   seq_state_t   - sequencer FSM states
//   FUNCT3_SW     - funct3 code for a word store on the dmem port
//   LED_ADDR_DEF  - default byte address of the LED/RGB register
//   RED..MAGENTA  - default colour words, COLOR_TABLE_DEF packs them (entry 0 in LSBs)
package led_seq_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, DWELL, STOP, DONE} seq_state_t;

  localparam logic [2:0]  FUNCT3_SW    = 3'b010;
  localparam logic [31:0] LED_ADDR_DEF = 32'hFFFF_FFFC;

  localparam logic [31:0] RED     = 32'hFFFF_0000;
  localparam logic [31:0] YELLOW  = 32'hFFFF_FF00;
  localparam logic [31:0] GREEN   = 32'hFF00_FF00;
  localparam logic [31:0] CYAN    = 32'h0000_FFFF;
  localparam logic [31:0] BLUE    = 32'h0000_00FF;
  localparam logic [31:0] MAGENTA = 32'h00FF_00FF;

  localparam logic [6*32-1:0] COLOR_TABLE_DEF = {MAGENTA, BLUE, CYAN, GREEN, YELLOW, RED};
endpackage

// File: rtl/led_sequencer_if.sv
// led_sequencer_if: data-memory write port driven by the LED sequencer.
//   dmem_wren     - one-cycle write strobe
//   dmem_address  - write byte address
//   dmem_data_in  - write data
//   funct3        - store width code
// master = sequencer side, slave = memory/mux side.
interface led_sequencer_if;
  logic        dmem_wren;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic [2:0]  funct3;

  modport master (output dmem_wren, dmem_address, dmem_data_in, funct3);
  modport slave  (input  dmem_wren, dmem_address, dmem_data_in, funct3);
endinterface

// File: rtl/led_sequencer_dwell_timer.sv
// led_dwell_timer: loadable down-counter with a run/freeze control.
//   clk, reset - clock, async active-high reset (counter clears to 0)
//   load       - load load_val (has priority over run)
//   load_val   - value loaded into the counter
//   run        - decrement while high; the counter saturates at 0
//   zero       - counter is 0
module led_dwell_timer #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (run && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: steps through a colour table, writing each word to the LED
// register over the dmem write port and holding it for DWELL_CYCLES cycles.
//   clk, reset  - clock, async active-high reset
//   enable      - level: 1 runs the sequence, 0 stops it (blank write)
//   one_shot    - latched at start: 1 = single pass then DONE, 0 = loop
//   pause       - freezes dwell timer and step index while in DWELL
//   pingpong    - (LED_SEQ_PINGPONG_EN only) latched at start: bounce sequencing
//   dmem        - dmem write port (master)
//   step_idx    - index of the colour currently shown
//   busy, done  - status (WRITE/DWELL/STOP, DONE)
// Optional feature macro: LED_SEQ_PINGPONG_EN.
// All outputs are a registered decode of the current state, so every output
// lags the FSM state by one cycle (first write two cycles after enable rises).
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int                     N_STEPS      = 6,
  parameter int                     DWELL_W      = 22,
  parameter int                     DWELL_CYCLES = 3000000,
  parameter logic [31:0]            LED_ADDR     = LED_ADDR_DEF,
  parameter logic [N_STEPS*32-1:0]  COLOR_TABLE  = COLOR_TABLE_DEF,
  parameter logic [31:0]            OFF_COLOR    = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       one_shot,
  input  logic                       pause,
`ifdef LED_SEQ_PINGPONG_EN
  input  logic                       pingpong,
`endif
  led_sequencer_if.master            dmem,
  output logic [$clog2(N_STEPS)-1:0] step_idx,
  output logic                       busy,
  output logic                       done
);
  localparam int             IW   = $clog2(N_STEPS);
  localparam logic [IW-1:0]  LAST = IW'(N_STEPS - 1);

  seq_state_t    state;
  logic [IW-1:0] idx, idx_nxt;
  logic          os_q, last_step, zero;

  assign dmem.dmem_address = LED_ADDR;
  assign dmem.funct3       = FUNCT3_SW;

  led_dwell_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state == WRITE),
    .load_val (DWELL_W'(DWELL_CYCLES - 1)),
    .run      (state == DWELL && !pause),
    .zero     (zero)
  );

`ifdef LED_SEQ_PINGPONG_EN
  logic pp_q, dir_dn, dir_nxt;
`endif

  // Next colour index and "this is the final step of a one-shot pass".
  always_comb begin
    idx_nxt   = (idx == LAST) ? '0 : idx + 1'b1;
    last_step = (idx == LAST);
`ifdef LED_SEQ_PINGPONG_EN
    dir_nxt = dir_dn;
    if (pp_q) begin
      last_step = dir_dn && (idx == '0);
      if (!dir_dn) begin
        if (idx == LAST) begin idx_nxt = idx - 1'b1; dir_nxt = 1'b1; end
      end else if (idx == '0) begin
        idx_nxt = IW'(1); dir_nxt = 1'b0;
      end else begin
        idx_nxt = idx - 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      os_q              <= 1'b0;
      dmem.dmem_wren    <= 1'b0;
      dmem.dmem_data_in <= '0;
      step_idx          <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
      pp_q              <= 1'b0;
      dir_dn            <= 1'b0;
`endif
    end else begin
      dmem.dmem_wren <= 1'b0;
      busy           <= (state == WRITE) || (state == DWELL) || (state == STOP);
      done           <= (state == DONE);
      step_idx       <= idx;
      case (state)
        IDLE: if (enable) begin
          os_q  <= one_shot;
          idx   <= '0;
          state <= WRITE;
`ifdef LED_SEQ_PINGPONG_EN
          pp_q   <= pingpong;
          dir_dn <= 1'b0;
`endif
        end
        // A stop request drops the pending colour write so the blank write
        // never lands back-to-back with it.
        WRITE: if (!enable) state <= STOP;
        else begin
          dmem.dmem_wren    <= 1'b1;
          dmem.dmem_data_in <= COLOR_TABLE[32*int'(idx) +: 32];
          state             <= DWELL;
        end
        DWELL: if (!enable) state <= STOP;
        else if (!pause && zero) begin
          if (last_step && os_q) state <= DONE;
          else begin
            idx   <= idx_nxt;
            state <= WRITE;
`ifdef LED_SEQ_PINGPONG_EN
            dir_dn <= dir_nxt;
`endif
          end
        end
        STOP: begin
          dmem.dmem_wren    <= 1'b1;
          dmem.dmem_data_in <= OFF_COLOR;
          idx               <= '0;
          step_idx          <= '0;
          state             <= IDLE;
        end
        DONE:    if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;
  localparam int N = 6;
  localparam int D = 4;

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, one_shot = 1'b0, pause = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
  logic pingpong = 1'b0;
`endif
  logic [2:0] step_idx;
  logic       busy, done;

  led_sequencer_if bus ();

  led_sequencer #(.N_STEPS(N), .DWELL_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .one_shot (one_shot),
    .pause    (pause),
`ifdef LED_SEQ_PINGPONG_EN
    .pingpong (pingpong),
`endif
    .dmem     (bus),
    .step_idx (step_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [31:0] tbl [N] = '{32'hFFFF0000, 32'hFFFFFF00, 32'hFF00FF00,
                           32'h0000FFFF, 32'h000000FF, 32'h00FF00FF};

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The run is described by k = how many colour steps have begun and
  // j = cycle within the current step period (0 = write cycle, 1..D = hold).
  // The colour shown for step k comes from plain arithmetic on k.
  typedef enum int {P_IDLE, P_RUN, P_BLANK, P_DONE} phase_t;
  phase_t      ph = P_IDLE;
  int          k = 0, j = 0;
  bit          m_os = 0, m_pp = 0;
  logic        e_wren = 0, e_busy = 0, e_done = 0;
  logic [31:0] e_data = 0;
  logic [2:0]  e_idx = 0;

  function automatic int seq_at(input int kk, input bit pp);
    int p;
    if (pp) begin
      p = kk % (2*N - 2);
      return (p < N) ? p : 2*N - 2 - p;
    end
    return kk % N;
  endfunction

  function automatic int run_len(input bit pp);
    return pp ? 2*N - 1 : N;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = P_IDLE; k = 0; j = 0; m_os = 0; m_pp = 0;
      e_wren = 0; e_data = 0; e_idx = 0; e_busy = 0; e_done = 0;
    end else begin
      e_wren = (ph == P_RUN && j == 0 && enable) || ph == P_BLANK;
      if (e_wren) e_data = (ph == P_BLANK) ? 32'h0 : tbl[seq_at(k, m_pp)];
      if (ph == P_RUN)        e_idx = 3'(seq_at(k, m_pp));
      else if (ph == P_BLANK) e_idx = 3'd0;
      e_busy = (ph == P_RUN) || (ph == P_BLANK);
      e_done = (ph == P_DONE);
      case (ph)
        P_IDLE: if (enable) begin
          ph = P_RUN; k = 0; j = 0; m_os = one_shot;
`ifdef LED_SEQ_PINGPONG_EN
          m_pp = pingpong;
`else
          m_pp = 0;
`endif
        end
        P_RUN: if (!enable) ph = P_BLANK;
        else if (j == 0) j = 1;
        else if (!pause) begin
          if (j < D) j++;
          else if (m_os && k + 1 == run_len(m_pp)) ph = P_DONE;
          else begin k++; j = 0; end
        end
        P_BLANK: ph = P_IDLE;
        P_DONE:  if (!enable) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_wren = 0;
  always @(negedge clk) begin
    chk("wren",   32'(bus.dmem_wren),    32'(e_wren));
    chk("data",   bus.dmem_data_in,      e_data);
    chk("addr",   bus.dmem_address,      32'hFFFFFFFC);
    chk("funct3", 32'(bus.funct3),       32'h2);
    chk("idx",    32'(step_idx),         32'(e_idx));
    chk("busy",   32'(busy),             32'(e_busy));
    chk("done",   32'(done),             32'(e_done));
    chk("b2b_wren", 32'(bus.dmem_wren & prev_wren), 32'h0);
    prev_wren = bus.dmem_wren;
  end

  // Count negedges until a write strobe is seen (bounded).
  task automatic wait_wren(input int maxc, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.dmem_wren && n < maxc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wren"}, 32'(bus.dmem_wren), 32'h0);
    chk({tag, "_data"}, bus.dmem_data_in,   32'h0);
    chk({tag, "_addr"}, bus.dmem_address,   32'hFFFFFFFC);
    chk({tag, "_idx"},  32'(step_idx),      32'h0);
    chk({tag, "_busy"}, 32'(busy),          32'h0);
    chk({tag, "_done"}, 32'(done),          32'h0);
  endtask

  initial begin
    int n, cnt;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    #2 reset = 1'b0;

    // loop mode: first write latency 2, then every D+1 cycles, with wrap
    @(negedge clk); enable = 1'b1;
    wait_wren(20, n);
    chk("lat_first", 32'(n), 32'd2);
    chk("w0", bus.dmem_data_in, 32'hFFFF0000);
    chk("w0_idx", 32'(step_idx), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      wait_wren(20, n);
      chk($sformatf("period%0d", i), 32'(n), 32'd5);
      chk($sformatf("w%0d", i), bus.dmem_data_in, tbl[i % N]);
    end

    // pause 10 cycles in DWELL of step 2: next write 10 cycles late
    pause = 1'b1;
    repeat (10) @(negedge clk);
    chk("pause_idx", 32'(step_idx), 32'd2);
    pause = 1'b0;
    wait_wren(20, n);
    chk("pause_gap", 32'(n), 32'd5);
    chk("pause_w3", bus.dmem_data_in, 32'h0000FFFF);

    // stop during DWELL of step 4: one blank write, then busy low
    wait_wren(20, n);
    chk("w4_idx", 32'(step_idx), 32'd4);
    enable = 1'b0;
    wait_wren(6, n);
    chk("stop_lat", 32'(n), 32'd2);
    chk("stop_data", bus.dmem_data_in, 32'h0);
    chk("stop_idx", 32'(step_idx), 32'd0);
    @(negedge clk);
    chk("stop_busy", 32'(busy), 32'd0);

    // one-shot: exactly N writes, done one step period later, then idle
    @(negedge clk); enable = 1'b1; one_shot = 1'b1;
    for (int i = 0; i < N; i++) begin
      wait_wren(20, n);
      chk($sformatf("os_w%0d", i), bus.dmem_data_in, tbl[i]);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    chk("os_done_lat", 32'(n), 32'd5);
    cnt = 0;
    repeat (30) begin @(negedge clk); if (bus.dmem_wren) cnt++; end
    chk("os_no_writes", 32'(cnt), 32'd0);
    chk("os_done_hold", 32'(done), 32'd1);
    enable = 1'b0; one_shot = 1'b0;
    repeat (2) @(negedge clk);
    chk("os_done_clr", 32'(done), 32'd0);
    chk("os_idle_busy", 32'(busy), 32'd0);

    // async reset mid-DWELL at step 3
    @(negedge clk); enable = 1'b1;
    for (int i = 0; i < 4; i++) wait_wren(20, n);
    chk("pre_rst_idx", 32'(step_idx), 32'd3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_rst");
    enable = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    cnt = 0;
    repeat (2) begin @(negedge clk); if (bus.dmem_wren) cnt++; end
    chk("post_rst_quiet", 32'(cnt), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (enable) begin if ($urandom_range(0, 59) == 0) enable = 1'b0; end
      else if ($urandom_range(0, 7) == 0) enable = 1'b1;
      pause    = ($urandom_range(0, 4) == 0);
      one_shot = 1'($urandom_range(0, 1));
`ifdef LED_SEQ_PINGPONG_EN
      pingpong = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 999) == 0) begin #2 reset = 1'b1; #2 reset = 1'b0; end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
